button_conditioner: RTL and testbench

Per-button debounce and edge-detect stage for player controls.
Sits directly downstream of the two-flop Synchronizer instances, one per raw button pin, and consumes their sync outputs.
Produces clean held levels plus single-cycle press/release pulses for the game FSM.
All channels are independent and share one clock.

---
 rtl/button_pkg.sv | 29 ++
 rtl/btn_debounce_ch.sv | 173 +++++++++++++++++
 rtl/button_conditioner.sv | 57 +++++
 tb/tb_button_conditioner.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and helpers for the button conditioner.
//
// Contents:
//   btn_state_t  per-channel debounce state (UP, ARM_DN, DOWN, ARM_UP)
//   cnt_width    width of the debounce sample counter for a given debounce length
//   rpt_width    width of the auto-repeat counter for given delay/period values
package button_pkg;

    typedef enum logic [1:0] {
        UP     = 2'd0,
        ARM_DN = 2'd1,
        DOWN   = 2'd2,
        ARM_UP = 2'd3
    } btn_state_t;

    // The counter must be able to hold the value d itself. A non-positive d is
    // rejected at elaboration elsewhere; it is clamped here so that the width
    // stays legal until that check fires.
    function automatic int cnt_width(input int d);
        return (d < 1) ? 1 : $clog2(d + 1);
    endfunction

    function automatic int rpt_width(input int delay, input int period);
        int m;
        m = (delay > period) ? delay : period;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// Single button channel: debounce FSM, press/release pulse generation and,
// when the AUTO_REPEAT_EN macro is defined, an auto-repeat press generator.
//
// Ports:
//   clock          system clock, all state on posedge
//   reset_L        asynchronous active-low reset
//   sync_in        synchronized button sample, 1 = pressed
//   level          debounced held level, registered
//   press_pulse    1-cycle pulse on accepted press (and auto-repeat)
//   release_pulse  1-cycle pulse on accepted release
//   state          current FSM state, for debug observation
//
// Macro AUTO_REPEAT_EN: when defined, a held button re-pulses press_pulse
// REPEAT_DELAY cycles after acceptance and every REPEAT_PERIOD cycles after.
module btn_debounce_ch
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 2000,
    parameter int REPEAT_PERIOD   = 500
) (
    input  logic       clock,
    input  logic       reset_L,
    input  logic       sync_in,
    output logic       level,
    output logic       press_pulse,
    output logic       release_pulse,
    output btn_state_t state
);

    localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam bit              SINGLE   = (DEBOUNCE_CYCLES == 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("btn_debounce_ch: DEBOUNCE_CYCLES must be at least 1");
    end
    if (REPEAT_PERIOD < 1 || REPEAT_DELAY < 1) begin : g_bad_repeat
        $error("btn_debounce_ch: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end

    // Counts consecutive samples that disagree with the accepted level. It is
    // cleared whenever the state settles, so it never exceeds DEBOUNCE_CYCLES-1
    // while stored, and the accepting edge is the one where it would reach D.
    logic [CNT_W-1:0] cnt;

`ifdef AUTO_REPEAT_EN
    localparam int               RPT_W     = rpt_width(REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

    // rpt counts cycles since the last press pulse; repeating tells whether
    // the initial delay or the shorter period is being timed.
    logic [RPT_W-1:0] rpt;
    logic             repeating;
    logic             held_now;
    logic             leave_up;

    always_comb begin
        held_now = (state == DOWN) || (state == ARM_UP);
        leave_up = 1'b0;
        if (!sync_in) begin
            if (state == ARM_UP && cnt == CNT_LAST) leave_up = 1'b1;
            if (SINGLE && state == DOWN)            leave_up = 1'b1;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state         <= UP;
            cnt           <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rpt           <= '0;
            repeating     <= 1'b0;
`endif
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                UP: begin
                    if (sync_in) begin
                        if (SINGLE) begin
                            state       <= DOWN;
                            level       <= 1'b1;
                            press_pulse <= 1'b1;
`ifdef AUTO_REPEAT_EN
                            rpt         <= '0;
                            repeating   <= 1'b0;
`endif
                        end else begin
                            state <= ARM_DN;
                            cnt   <= CNT_ONE;
                        end
                    end
                end
                ARM_DN: begin
                    if (!sync_in) begin
                        state <= UP;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state       <= DOWN;
                        cnt         <= '0;
                        level       <= 1'b1;
                        press_pulse <= 1'b1;
`ifdef AUTO_REPEAT_EN
                        rpt         <= '0;
                        repeating   <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DOWN: begin
                    if (!sync_in) begin
                        if (SINGLE) begin
                            state         <= UP;
                            level         <= 1'b0;
                            release_pulse <= 1'b1;
                        end else begin
                            state <= ARM_UP;
                            cnt   <= CNT_ONE;
                        end
                    end
                end
                ARM_UP: begin
                    if (sync_in) begin
                        state <= DOWN;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state         <= UP;
                        cnt           <= '0;
                        level         <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= UP;
                    cnt   <= '0;
                end
            endcase

`ifdef AUTO_REPEAT_EN
            // A bounce back from ARM_UP to DOWN is still the same hold, so the
            // repeat timer only restarts on an accepted press. On the edge that
            // releases, leave_up suppresses the repeat so release wins.
            if (held_now && !leave_up) begin
                if (!repeating) begin
                    if (rpt == RPT_FIRST) begin
                        press_pulse <= 1'b1;
                        rpt         <= '0;
                        repeating   <= 1'b1;
                    end else begin
                        rpt <= rpt + RPT_W'(1);
                    end
                end else if (rpt == RPT_NEXT) begin
                    press_pulse <= 1'b1;
                    rpt         <= '0;
                end else begin
                    rpt <= rpt + RPT_W'(1);
                end
            end
`endif
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Debounce and edge-detect stage for NUM_BTN independent button channels fed
// from synchronizer outputs.
//
// Ports:
//   clock        system clock, all state on posedge
//   reset_L      asynchronous active-low reset
//   btn_sync     synchronized button samples, 1 = pressed
//   btn_level    debounced held level per channel, registered
//   btn_press    1-cycle pulse per channel on accepted press (and auto-repeat)
//   btn_release  1-cycle pulse per channel on accepted release
//   any_press    OR of btn_press, same cycle
//   dbg_state    per-channel FSM state, channel i at bits [2*i+1:2*i]
//
// Macro AUTO_REPEAT_EN: enables per-channel auto-repeat press pulses.
module button_conditioner
    import button_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 2000,
    parameter int REPEAT_PERIOD   = 500
) (
    input  logic                   clock,
    input  logic                   reset_L,
    input  logic [NUM_BTN-1:0]     btn_sync,
    output logic [NUM_BTN-1:0]     btn_level,
    output logic [NUM_BTN-1:0]     btn_press,
    output logic [NUM_BTN-1:0]     btn_release,
    output logic                   any_press,
    output logic [2*NUM_BTN-1:0]   dbg_state
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_state_t ch_state;

        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clock         (clock),
            .reset_L       (reset_L),
            .sync_in       (btn_sync[i]),
            .level         (btn_level[i]),
            .press_pulse   (btn_press[i]),
            .release_pulse (btn_release[i]),
            .state         (ch_state)
        );

        assign dbg_state[2*i +: 2] = ch_state;
    end

    // Every btn_press bit is a flop output, so this OR changes in the same
    // cycle as the press pulses it summarises.
    assign any_press = |btn_press;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

    localparam int NB = 4;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic              clock;
    logic              reset_L;
    logic [NB-1:0]     btn_sync;
    logic [NB-1:0]     btn_level;
    logic [NB-1:0]     btn_press;
    logic [NB-1:0]     btn_release;
    logic              any_press;
    logic [2*NB-1:0]   dbg_state;

    int n_compared;
    int n_mismatched;

    // Reference model: per channel, the accepted level, how many consecutive
    // samples have disagreed with it, and how long it has been held down.
    logic [NB-1:0] exp_level;
    logic [NB-1:0] exp_press;
    logic [NB-1:0] exp_release;
    int            run_len [NB];
    int            held    [NB];

    button_conditioner #(
        .NUM_BTN         (NB),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clock       (clock),
        .reset_L     (reset_L),
        .btn_sync    (btn_sync),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .any_press   (any_press),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    task automatic model_reset();
        exp_level   = '0;
        exp_press   = '0;
        exp_release = '0;
        for (int c = 0; c < NB; c++) begin
            run_len[c] = 0;
            held[c]    = 0;
        end
    endtask

    task automatic model_step(input logic [NB-1:0] s);
        exp_press   = '0;
        exp_release = '0;
        for (int c = 0; c < NB; c++) begin
            if (s[c] != exp_level[c]) run_len[c]++;
            else                      run_len[c] = 0;
            if (run_len[c] == D) begin
                run_len[c]   = 0;
                exp_level[c] = s[c];
                if (s[c]) begin
                    exp_press[c] = 1'b1;
                    held[c]      = 0;
                end else begin
                    exp_release[c] = 1'b1;
                end
            end else if (exp_level[c]) begin
                held[c]++;
`ifdef AUTO_REPEAT_EN
                if (held[c] == RD || (held[c] > RD && (held[c] - RD) % RP == 0))
                    exp_press[c] = 1'b1;
`endif
            end
        end
    endtask

    // ---------------- driver ----------------
    // Applies one sample on the falling edge, lets the rising edge take it,
    // advances the model with the same sample and leaves time at edge+1.
    task automatic step(input logic [NB-1:0] s);
        @(negedge clock);
        btn_sync = s;
        @(posedge clock);
        model_step(s);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_L  = 1'b0;
        btn_sync = '0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        n_compared++;
        if ({btn_level, btn_press, btn_release, any_press} !== '0) begin
            n_mismatched++;
            $display("FAIL reset_outputs: got lvl=%b prs=%b rel=%b any=%b, want all 0",
                     btn_level, btn_press, btn_release, any_press);
        end
        n_compared++;
        if (dbg_state !== '0) begin
            n_mismatched++;
            $display("FAIL reset_state: got %b, want all UP (0)", dbg_state);
        end
        @(negedge clock);
        reset_L = 1'b1;
    endtask

    task automatic test_clean_press();
        for (int e = 1; e <= 5; e++) begin
            step(4'b0001);
            n_compared++;
            if (btn_level !== ((e >= 4) ? 4'b0001 : 4'b0000)) begin
                n_mismatched++;
                $display("FAIL clean_press_level edge %0d: got %b, want %b",
                         e, btn_level, (e >= 4) ? 4'b0001 : 4'b0000);
            end
            n_compared++;
            if (btn_press !== ((e == 4) ? 4'b0001 : 4'b0000) || any_press !== (e == 4)) begin
                n_mismatched++;
                $display("FAIL clean_press_pulse edge %0d: got prs=%b any=%b", e, btn_press, any_press);
            end
        end
    endtask

    task automatic test_release();
        for (int e = 1; e <= 5; e++) begin
            step(4'b0000);
            n_compared++;
            if (btn_level !== ((e >= 4) ? 4'b0000 : 4'b0001)) begin
                n_mismatched++;
                $display("FAIL release_level edge %0d: got %b", e, btn_level);
            end
            n_compared++;
            if (btn_release !== ((e == 4) ? 4'b0001 : 4'b0000) || btn_press !== 4'b0000) begin
                n_mismatched++;
                $display("FAIL release_pulse edge %0d: got rel=%b prs=%b", e, btn_release, btn_press);
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] pat;
        int presses;
        int press_edge;
        pat        = 8'b1111_0111; // applied LSB first: 1,1,1,0,1,1,1,1
        presses    = 0;
        press_edge = -1;
        for (int e = 0; e < 8; e++) begin
            step({2'b00, pat[e], 1'b0});
            if (btn_press[1]) begin
                presses++;
                press_edge = e + 1;
            end
        end
        step(4'b0010);
        if (btn_press[1]) presses++;
        n_compared++;
        if (presses !== 1 || press_edge !== 8) begin
            n_mismatched++;
            $display("FAIL bounce_press: got %0d pulses at edge %0d, want 1 at edge 8",
                     presses, press_edge);
        end
        n_compared++;
        if (btn_level !== 4'b0010) begin
            n_mismatched++;
            $display("FAIL bounce_level: got %b, want 0010", btn_level);
        end
        repeat (5) step(4'b0000);
    endtask

    task automatic test_reset_mid_count();
        repeat (4) step(4'b0010);
        repeat (3) step(4'b0011);
        n_compared++;
        if (btn_level !== exp_level || exp_level !== 4'b0010) begin
            n_mismatched++;
            $display("FAIL midcount_setup: got lvl=%b, want 0010", btn_level);
        end
        @(negedge clock);
        reset_L = 1'b0;
        model_reset();
        #1;
        n_compared++;
        if ({btn_level, btn_press, btn_release, any_press, dbg_state} !== '0) begin
            n_mismatched++;
            $display("FAIL midcount_async_reset: got lvl=%b prs=%b rel=%b any=%b st=%b, want 0",
                     btn_level, btn_press, btn_release, any_press, dbg_state);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_L  = 1'b1;
        btn_sync = 4'b0011;
        @(posedge clock);
        model_step(4'b0011);
        #1;
        for (int e = 2; e <= 4; e++) begin
            step(4'b0011);
            n_compared++;
            if (btn_level !== ((e == 4) ? 4'b0011 : 4'b0000) ||
                btn_press !== ((e == 4) ? 4'b0011 : 4'b0000)) begin
                n_mismatched++;
                $display("FAIL midcount_fresh edge %0d: got lvl=%b prs=%b", e, btn_level, btn_press);
            end
        end
        repeat (6) step(4'b0000);
    endtask

    task automatic test_simultaneous();
        for (int e = 1; e <= 5; e++) begin
            step(4'b0101);
            n_compared++;
            if (btn_press !== ((e == 4) ? 4'b0101 : 4'b0000) || any_press !== (e == 4)) begin
                n_mismatched++;
                $display("FAIL simultaneous edge %0d: got prs=%b any=%b", e, btn_press, any_press);
            end
        end
        repeat (5) step(4'b0000);
    endtask

    task automatic test_auto_repeat();
        int presses;
        int late_presses;
        int releases;
        int expected_presses;
        int first_repeat;
        presses      = 0;
        late_presses = 0;
        releases     = 0;
        first_repeat = -1;
        for (int e = 1; e <= 40; e++) begin
            step(4'b1000);
            if (btn_press[3]) begin
                presses++;
                if (e > 4 && first_repeat < 0) first_repeat = e;
            end
            n_compared++;
            if (btn_press !== exp_press || btn_level !== exp_level) begin
                n_mismatched++;
                $display("FAIL repeat_hold edge %0d: got prs=%b lvl=%b, want prs=%b lvl=%b",
                         e, btn_press, btn_level, exp_press, exp_level);
            end
        end
`ifdef AUTO_REPEAT_EN
        expected_presses = 7;
        n_compared++;
        if (first_repeat !== 4 + RD) begin
            n_mismatched++;
            $display("FAIL repeat_first: got edge %0d, want %0d", first_repeat, 4 + RD);
        end
`else
        expected_presses = 1;
`endif
        n_compared++;
        if (presses !== expected_presses) begin
            n_mismatched++;
            $display("FAIL repeat_count: got %0d press pulses, want %0d", presses, expected_presses);
        end
        for (int e = 1; e <= 20; e++) begin
            step(4'b0000);
            if (btn_press[3])   late_presses++;
            if (btn_release[3]) releases++;
        end
        n_compared++;
        if (late_presses !== 0 || releases !== 1) begin
            n_mismatched++;
            $display("FAIL repeat_after_release: got %0d presses %0d releases, want 0 and 1",
                     late_presses, releases);
        end
    endtask

    task automatic test_random();
        logic [NB-1:0] target;
        logic [NB-1:0] s;
        target = '0;
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < NB; c++) begin
                if ($urandom_range(0, 24) == 0) target[c] = ~target[c];
            end
            s = target;
            for (int c = 0; c < NB; c++) begin
                if ($urandom_range(0, 5) == 0) s[c] = ~s[c];
            end
            step(s);
            n_compared++;
            if (btn_level !== exp_level || btn_press !== exp_press ||
                btn_release !== exp_release || any_press !== (|exp_press)) begin
                n_mismatched++;
                $display("FAIL random cycle %0d: got lvl=%b prs=%b rel=%b any=%b, want lvl=%b prs=%b rel=%b",
                         n, btn_level, btn_press, btn_release, any_press,
                         exp_level, exp_press, exp_release);
            end
            n_compared++;
            if ((btn_press & btn_release) !== '0) begin
                n_mismatched++;
                $display("FAIL random_exclusive cycle %0d: got prs=%b rel=%b, want no overlap",
                         n, btn_press, btn_release);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        btn_sync     = '0;
        reset_L      = 1'b0;
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_reset_mid_count();
        test_simultaneous();
        test_auto_repeat();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
